// File: rtl/artillery_engine_if.sv
//==============================================================================
// Module      : artillery_engine_if
// Description : Keypad-pulse and game-state bundle between the artillery engine
//               and its input/display drivers. The master side drives the
//               debounced pulses; the slave side (the engine) drives the state.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface artillery_engine_if #(
  parameter int FIELD_W  = 8,
  parameter int MAX_LIFE = 3,
  parameter int POWER_W  = 3
);
  localparam int PW = $clog2(FIELD_W);
  localparam int LW = $clog2(MAX_LIFE + 1);

  logic               move_left;
  logic               move_right;
  logic               fire_btn;
  logic [PW-1:0]      tank1_pos;
  logic [PW-1:0]      tank2_pos;
  logic [LW-1:0]      tank1_life;
  logic [LW-1:0]      tank2_life;
  logic               turn;
  logic [POWER_W-1:0] power;
  logic               shell_valid;
  logic [PW-1:0]      shell_pos;
  logic               hit;
  logic               game_over;
  logic               winner;

  modport master (
    output move_left, move_right, fire_btn,
    input  tank1_pos, tank2_pos, tank1_life, tank2_life, turn, power,
    input  shell_valid, shell_pos, hit, game_over, winner
  );

  modport slave (
    input  move_left, move_right, fire_btn,
    output tank1_pos, tank2_pos, tank1_life, tank2_life, turn, power,
    output shell_valid, shell_pos, hit, game_over, winner
  );
endinterface

`default_nettype wire

// File: rtl/artillery_engine.sv
//==============================================================================
// Module      : artillery_engine
// Description : Two-tank artillery game engine. Owns tank positions, lives,
//               turn, cannon charge, shell flight, hit resolution, game over
//               and restart. All state outputs are registered.
//               Optional feature macro: ARTILLERY_SPLASH_EN - a landing cell
//               adjacent to the opponent also counts as a hit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module artillery_engine #(
  parameter int FIELD_W    = 8,
  parameter int MAX_LIFE   = 3,
  parameter int POWER_W    = 3,
  parameter int STEP_DIV   = 4,
  parameter int CHARGE_DIV = 2
) (
  input  wire logic          clk,
  input  wire logic          nrst,
  artillery_engine_if.slave  bus
);

  localparam int PW      = $clog2(FIELD_W);
  localparam int LW      = $clog2(MAX_LIFE + 1);
  localparam int DIV_MAX = (STEP_DIV > CHARGE_DIV) ? STEP_DIV : CHARGE_DIV;
  localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [2:0] c_st_aim     = 3'd0;
  localparam logic [2:0] c_st_charge  = 3'd1;
  localparam logic [2:0] c_st_flight  = 3'd2;
  localparam logic [2:0] c_st_resolve = 3'd3;
  localparam logic [2:0] c_st_over    = 3'd4;

  localparam logic [PW-1:0]      c_pos_max     = PW'(FIELD_W - 1);
  localparam logic [PW-1:0]      c_pos_one     = PW'(1);
  localparam logic [LW-1:0]      c_life_init   = LW'(MAX_LIFE);
  localparam logic [LW-1:0]      c_life_one    = LW'(1);
  localparam logic [POWER_W-1:0] c_power_one   = POWER_W'(1);
  localparam logic [POWER_W-1:0] c_power_max   = {POWER_W{1'b1}};
  localparam logic [CW-1:0]      c_cnt_one     = CW'(1);
  localparam logic [CW-1:0]      c_step_last   = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0]      c_charge_last = CW'(CHARGE_DIV - 1);

  logic [2:0]         r_state, w_state_nxt;
  logic [PW-1:0]      r_tank1_pos, w_tank1_pos_nxt;
  logic [PW-1:0]      r_tank2_pos, w_tank2_pos_nxt;
  logic [LW-1:0]      r_tank1_life, w_tank1_life_nxt;
  logic [LW-1:0]      r_tank2_life, w_tank2_life_nxt;
  logic               r_turn, w_turn_nxt;
  logic [POWER_W-1:0] r_power, w_power_nxt;
  logic               r_shell_valid, w_shell_valid_nxt;
  logic [PW-1:0]      r_shell_pos, w_shell_pos_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_game_over, w_game_over_nxt;
  logic               r_winner, w_winner_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [POWER_W-1:0] r_k, w_k_nxt;
  logic               r_kill, w_kill_nxt;

  logic [PW-1:0] w_shooter_pos;
  logic [PW-1:0] w_opp_pos;
  logic [LW-1:0] w_opp_life;
  logic          w_step_end;
  logic          w_last_step;
  logic          w_at_edge;
  logic          w_fly_done;
  logic          w_match;
  logic          w_land_hit;

  assign w_shooter_pos = r_turn ? r_tank2_pos : r_tank1_pos;
  assign w_opp_pos     = r_turn ? r_tank1_pos : r_tank2_pos;
  assign w_opp_life    = r_turn ? r_tank1_life : r_tank2_life;
  assign w_step_end    = (r_cnt == c_step_last);
  assign w_last_step   = (r_k == r_power);
  // The next cell in the flight direction would leave the field
  assign w_at_edge     = r_turn ? (r_shell_pos == '0) : (r_shell_pos == c_pos_max);
  assign w_fly_done    = w_step_end && (w_last_step || w_at_edge);

`ifdef ARTILLERY_SPLASH_EN
  logic [PW-1:0] w_gap;
  assign w_gap   = (r_shell_pos > w_opp_pos) ? (r_shell_pos - w_opp_pos)
                                             : (w_opp_pos - r_shell_pos);
  assign w_match = (w_gap <= c_pos_one);
`else
  assign w_match = (r_shell_pos == w_opp_pos);
`endif

  // Completing the final step is a landing; stopping at the field edge is a miss
  assign w_land_hit = w_last_step && w_match;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= c_st_aim;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_aim:     if (bus.fire_btn) w_state_nxt = c_st_charge;
      c_st_charge:  if (bus.fire_btn) w_state_nxt = c_st_flight;
      c_st_flight:  if (w_fly_done)   w_state_nxt = c_st_resolve;
      c_st_resolve: w_state_nxt = r_kill ? c_st_over : c_st_aim;
      c_st_over:    if (bus.fire_btn) w_state_nxt = c_st_aim;
      default:      w_state_nxt = c_st_aim;
    endcase
  end

  // Next values of all game-state registers for the current state
  always_comb begin
    w_tank1_pos_nxt   = r_tank1_pos;
    w_tank2_pos_nxt   = r_tank2_pos;
    w_tank1_life_nxt  = r_tank1_life;
    w_tank2_life_nxt  = r_tank2_life;
    w_turn_nxt        = r_turn;
    w_power_nxt       = r_power;
    w_shell_valid_nxt = r_shell_valid;
    w_shell_pos_nxt   = r_shell_pos;
    w_hit_nxt         = 1'b0;
    w_game_over_nxt   = r_game_over;
    w_winner_nxt      = r_winner;
    w_cnt_nxt         = r_cnt;
    w_k_nxt           = r_k;
    w_kill_nxt        = r_kill;
    case (r_state)
      c_st_aim: begin
        if (bus.fire_btn) begin
          w_power_nxt = c_power_one;
          w_cnt_nxt   = '0;
        end else if (bus.move_left && !bus.move_right) begin
          if (!r_turn) begin
            if (r_tank1_pos != '0) w_tank1_pos_nxt = r_tank1_pos - c_pos_one;
          end else begin
            if (r_tank2_pos > r_tank1_pos + c_pos_one) w_tank2_pos_nxt = r_tank2_pos - c_pos_one;
          end
        end else if (bus.move_right && !bus.move_left) begin
          if (!r_turn) begin
            if (r_tank1_pos + c_pos_one < r_tank2_pos) w_tank1_pos_nxt = r_tank1_pos + c_pos_one;
          end else begin
            if (r_tank2_pos != c_pos_max) w_tank2_pos_nxt = r_tank2_pos + c_pos_one;
          end
        end
      end
      c_st_charge: begin
        if (bus.fire_btn) begin
          w_shell_valid_nxt = 1'b1;
          w_shell_pos_nxt   = r_turn ? (w_shooter_pos - c_pos_one) : (w_shooter_pos + c_pos_one);
          w_k_nxt           = c_power_one;
          w_cnt_nxt         = '0;
        end else if (r_cnt == c_charge_last) begin
          w_cnt_nxt   = '0;
          w_power_nxt = (r_power == c_power_max) ? c_power_one : (r_power + c_power_one);
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      c_st_flight: begin
        if (!w_step_end) begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end else if (w_fly_done) begin
          // Resolution is applied on the edge entering RESOLVE so hit, life
          // and turn all change together.
          w_cnt_nxt         = '0;
          w_shell_valid_nxt = 1'b0;
          if (w_land_hit) begin
            w_hit_nxt = 1'b1;
            if (r_turn) w_tank1_life_nxt = r_tank1_life - c_life_one;
            else        w_tank2_life_nxt = r_tank2_life - c_life_one;
          end
          if (w_land_hit && (w_opp_life == c_life_one)) begin
            w_kill_nxt = 1'b1;
          end else begin
            w_turn_nxt  = ~r_turn;
            w_power_nxt = '0;
          end
        end else begin
          w_cnt_nxt       = '0;
          w_k_nxt         = r_k + c_power_one;
          w_shell_pos_nxt = r_turn ? (r_shell_pos - c_pos_one) : (r_shell_pos + c_pos_one);
        end
      end
      c_st_resolve: begin
        if (r_kill) begin
          w_game_over_nxt = 1'b1;
          w_winner_nxt    = r_turn;
          w_kill_nxt      = 1'b0;
        end
      end
      c_st_over: begin
        // Restart: everything returns to its reset value except the winner
        if (bus.fire_btn) begin
          w_tank1_pos_nxt   = '0;
          w_tank2_pos_nxt   = c_pos_max;
          w_tank1_life_nxt  = c_life_init;
          w_tank2_life_nxt  = c_life_init;
          w_turn_nxt        = 1'b0;
          w_power_nxt       = '0;
          w_shell_valid_nxt = 1'b0;
          w_shell_pos_nxt   = '0;
          w_game_over_nxt   = 1'b0;
          w_cnt_nxt         = '0;
          w_k_nxt           = '0;
          w_kill_nxt        = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Game-state registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tank1_pos   <= '0;
      r_tank2_pos   <= c_pos_max;
      r_tank1_life  <= c_life_init;
      r_tank2_life  <= c_life_init;
      r_turn        <= 1'b0;
      r_power       <= '0;
      r_shell_valid <= 1'b0;
      r_shell_pos   <= '0;
      r_hit         <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_cnt         <= '0;
      r_k           <= '0;
      r_kill        <= 1'b0;
    end else begin
      r_tank1_pos   <= w_tank1_pos_nxt;
      r_tank2_pos   <= w_tank2_pos_nxt;
      r_tank1_life  <= w_tank1_life_nxt;
      r_tank2_life  <= w_tank2_life_nxt;
      r_turn        <= w_turn_nxt;
      r_power       <= w_power_nxt;
      r_shell_valid <= w_shell_valid_nxt;
      r_shell_pos   <= w_shell_pos_nxt;
      r_hit         <= w_hit_nxt;
      r_game_over   <= w_game_over_nxt;
      r_winner      <= w_winner_nxt;
      r_cnt         <= w_cnt_nxt;
      r_k           <= w_k_nxt;
      r_kill        <= w_kill_nxt;
    end
  end

  assign bus.tank1_pos   = r_tank1_pos;
  assign bus.tank2_pos   = r_tank2_pos;
  assign bus.tank1_life  = r_tank1_life;
  assign bus.tank2_life  = r_tank2_life;
  assign bus.turn        = r_turn;
  assign bus.power       = r_power;
  assign bus.shell_valid = r_shell_valid;
  assign bus.shell_pos   = r_shell_pos;
  assign bus.hit         = r_hit;
  assign bus.game_over   = r_game_over;
  assign bus.winner      = r_winner;

endmodule

`default_nettype wire
